n64_controller_responder: RTL and testbench

//  Controller-side end of the N64 single-wire protocol; emulates a standard pad toward a console/host poller.

---
 rtl/n64_pkg.sv | 36 +++
 rtl/n64_line_sync.sv | 32 +++
 rtl/n64_controller_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_n64_controller_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
// Shared N64 single-wire protocol constants, state encoding and helpers,
// used by both the controller responder and the host-side serial interface.
package n64_pkg;

  localparam logic [7:0]  CMD_INFO     = 8'h00;
  localparam logic [7:0]  CMD_POLL     = 8'h01;
  localparam logic [7:0]  CMD_RESET    = 8'hFF;
  localparam logic [23:0] STATUS_REPLY = 24'h05_00_02;

  localparam int BIT_US     = 4;
  localparam int SHORT_US   = 1;
  localparam int LONG_US    = 3;
  localparam int STOP_US    = 2;
  localparam int SAMPLE_US  = 2;
  localparam int RECOVER_US = 2;

  localparam int STATUS_BITS = 24;
  localparam int POLL_BITS   = 32;
  localparam int STOP_INDEX  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_BIT,
    ST_RX_GAP,
    ST_RX_STOP,
    ST_TURN,
    ST_TX_BIT,
    ST_TX_STOP,
    ST_RECOVER
  } n64_state_e;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchroniser for the shared N64 data line with edge strobes.
// Flops reset high because the idle open-drain line floats high.
module n64_line_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_line,
  output logic o_level,
  output logic o_fall,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;
  assign o_rise  = ~r_prev & r_sync;

endmodule

// File: rtl/n64_controller_responder.sv
// Controller (pad) end of the N64 single-wire protocol: decodes console
// command bytes and answers info/reset/poll with an open-drain reply.
module n64_controller_responder
  import n64_pkg::*;
#(
  parameter int US_CYCLES  = 100,
  parameter int TURN_US    = 2,
  parameter int TIMEOUT_US = 8
) (
  input  logic        PCLK,
  input  logic        controller_reset,
  input  logic        gpio_in,
  output logic        gpio_out,
  input  logic        respond_enable,
  input  logic [31:0] button_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        busy,
  output logic        rx_error
);

  localparam int TIMER_MAX = maxInt(TIMEOUT_US, BIT_US) * US_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX + 1);

  localparam logic [TW-1:0] SAMPLE_CYC   = TW'(SAMPLE_US * US_CYCLES);
  localparam logic [TW-1:0] GLITCH_CYC   = TW'(US_CYCLES / 4);
  localparam logic [TW-1:0] TIMEOUT_CYC  = TW'(TIMEOUT_US * US_CYCLES);
  localparam logic [TW-1:0] TURN_LAST    = TW'(TURN_US * US_CYCLES - 1);
  localparam logic [TW-1:0] BIT_LAST     = TW'(BIT_US * US_CYCLES - 1);
  localparam logic [TW-1:0] SHORT_CYC    = TW'(SHORT_US * US_CYCLES);
  localparam logic [TW-1:0] LONG_CYC     = TW'(LONG_US * US_CYCLES);
  localparam logic [TW-1:0] STOP_LAST    = TW'(STOP_US * US_CYCLES - 1);
  localparam logic [TW-1:0] RECOVER_LAST = TW'(RECOVER_US * US_CYCLES - 1);

  n64_state_e    r_state;
  n64_state_e    w_stateNext;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timerNext;
  logic [TW-1:0] r_riseAt;
  logic [TW-1:0] w_riseAtNext;
  logic [5:0]    r_bitCnt;
  logic [5:0]    w_bitCntNext;
  logic [31:0]   r_shift;
  logic [31:0]   w_shiftNext;
  logic [7:0]    r_cmdByte;
  logic [7:0]    w_cmdByteNext;
  logic          r_cmdValid;
  logic          w_cmdValidNext;
  logic          r_rxError;
  logic          w_rxErrorNext;
  logic [TW-1:0] w_lowCyc;
  logic          w_release;
  logic          w_level;
  logic          w_fall;
  logic          w_rise;

  n64_line_sync u_sync (
    .i_clk   (PCLK),
    .i_reset (controller_reset),
    .i_line  (gpio_in),
    .o_level (w_level),
    .o_fall  (w_fall),
    .o_rise  (w_rise)
  );

  always_ff @(posedge PCLK) begin
    if (controller_reset) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_riseAt   <= '0;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_cmdByte  <= 8'h00;
      r_cmdValid <= 1'b0;
      r_rxError  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_timer    <= w_timerNext;
      r_riseAt   <= w_riseAtNext;
      r_bitCnt   <= w_bitCntNext;
      r_shift    <= w_shiftNext;
      r_cmdByte  <= w_cmdByteNext;
      r_cmdValid <= w_cmdValidNext;
      r_rxError  <= w_rxErrorNext;
    end
  end

  // r_bitCnt counts received bits (8 = stop bit) and, while sending, reply bits left.
  always_comb begin
    w_stateNext    = r_state;
    w_timerNext    = r_timer;
    w_riseAtNext   = r_riseAt;
    w_bitCntNext   = r_bitCnt;
    w_shiftNext    = r_shift;
    w_cmdByteNext  = r_cmdByte;
    w_cmdValidNext = 1'b0;
    w_rxErrorNext  = 1'b0;
    w_release      = 1'b1;
    w_lowCyc       = r_shift[31] ? SHORT_CYC : LONG_CYC;

    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_stateNext  = ST_RX_BIT;
          w_timerNext  = '0;
          w_riseAtNext = '0;
          w_bitCntNext = '0;
        end
      end

      ST_RX_BIT: begin
        w_timerNext = r_timer + 1'b1;
        if (w_rise) begin
          w_riseAtNext = r_timer;
        end
        // A short low pulse is noise: fall back to whatever was waiting for this edge.
        if (w_rise && (r_timer < GLITCH_CYC)) begin
          if (r_bitCnt == 6'd0) begin
            w_stateNext = ST_IDLE;
          end else if (r_bitCnt == 6'(STOP_INDEX)) begin
            w_stateNext = ST_RX_STOP;
          end else begin
            w_stateNext = ST_RX_GAP;
          end
        end else if (r_timer == SAMPLE_CYC) begin
          if (r_bitCnt == 6'(STOP_INDEX)) begin
            if (w_level) begin
              w_cmdValidNext = 1'b1;
              w_cmdByteNext  = r_shift[7:0];
              // Turnaround is timed from the stop-bit rise, so preload the time already elapsed.
              w_timerNext    = SAMPLE_CYC - r_riseAt + 1'b1;
              if (respond_enable && ((r_shift[7:0] == CMD_INFO) || (r_shift[7:0] == CMD_RESET))) begin
                w_stateNext  = ST_TURN;
                w_shiftNext  = {STATUS_REPLY, 8'h00};
                w_bitCntNext = 6'(STATUS_BITS);
              end else if (respond_enable && (r_shift[7:0] == CMD_POLL)) begin
                w_stateNext  = ST_TURN;
                w_shiftNext  = button_data;
                w_bitCntNext = 6'(POLL_BITS);
              end else begin
                w_stateNext = ST_IDLE;
              end
            end else begin
              w_rxErrorNext = 1'b1;
              w_stateNext   = ST_IDLE;
            end
          end else begin
            w_shiftNext  = {r_shift[30:0], w_level};
            w_bitCntNext = r_bitCnt + 6'd1;
            w_stateNext  = (r_bitCnt == 6'd7) ? ST_RX_STOP : ST_RX_GAP;
          end
        end
      end

      ST_RX_GAP, ST_RX_STOP: begin
        if (w_fall) begin
          w_stateNext  = ST_RX_BIT;
          w_timerNext  = '0;
          w_riseAtNext = '0;
        end else if (r_timer >= TIMEOUT_CYC) begin
          w_rxErrorNext = 1'b1;
          w_stateNext   = ST_IDLE;
        end else begin
          w_timerNext = r_timer + 1'b1;
        end
      end

      ST_TURN: begin
        if (r_timer >= TURN_LAST) begin
          w_stateNext = ST_TX_BIT;
          w_timerNext = '0;
        end else begin
          w_timerNext = r_timer + 1'b1;
        end
      end

      ST_TX_BIT: begin
        w_release = (r_timer >= w_lowCyc);
        if (r_timer == BIT_LAST) begin
          w_timerNext  = '0;
          w_shiftNext  = {r_shift[30:0], 1'b0};
          w_bitCntNext = r_bitCnt - 6'd1;
          if (r_bitCnt == 6'd1) begin
            w_stateNext = ST_TX_STOP;
          end
        end else begin
          w_timerNext = r_timer + 1'b1;
        end
      end

      ST_TX_STOP: begin
        w_release = 1'b0;
        if (r_timer == STOP_LAST) begin
          w_stateNext = ST_RECOVER;
          w_timerNext = '0;
        end else begin
          w_timerNext = r_timer + 1'b1;
        end
      end

      ST_RECOVER: begin
        if (r_timer == RECOVER_LAST) begin
          w_stateNext = ST_IDLE;
          w_timerNext = '0;
        end else begin
          w_timerNext = r_timer + 1'b1;
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
        w_timerNext = '0;
      end
    endcase
  end

  assign gpio_out  = w_release;
  assign busy      = (r_state != ST_IDLE);
  assign cmd_valid = r_cmdValid;
  assign cmd_byte  = r_cmdByte;
  assign rx_error  = r_rxError;

endmodule

// File: tb/tb_n64_controller_responder.sv
// Console-side bench for n64_controller_responder: drives command bytes on the
// wired-AND line and measures the reply against a bit-level reference model.
module tb_n64_controller_responder;

  localparam int US         = 40;
  localparam int TURN_US    = 2;
  localparam int TIMEOUT_US = 8;

  logic        PCLK = 1'b0;
  logic        controller_reset;
  logic        gpio_in;
  logic        gpio_out;
  logic        respond_enable;
  logic [31:0] button_data;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        busy;
  logic        rx_error;
  logic        consoleDrive = 1'b1;

  int checkCount      = 0;
  int errorCount      = 0;
  int validCount      = 0;
  int errorPulseCount = 0;
  logic [7:0] validByte = 8'h00;

  bit          expBits[$];
  logic [31:0] expValue;

  n64_controller_responder #(
    .US_CYCLES  (US),
    .TURN_US    (TURN_US),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .PCLK             (PCLK),
    .controller_reset (controller_reset),
    .gpio_in          (gpio_in),
    .gpio_out         (gpio_out),
    .respond_enable   (respond_enable),
    .button_data      (button_data),
    .cmd_valid        (cmd_valid),
    .cmd_byte         (cmd_byte),
    .busy             (busy),
    .rx_error         (rx_error)
  );

  // Open-drain line: either end pulling low wins.
  assign gpio_in = consoleDrive & gpio_out;

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (cmd_valid === 1'b1) begin
      validCount++;
      validByte = cmd_byte;
    end
    if (rx_error === 1'b1) errorPulseCount++;
  end

  initial begin
    repeat (150000) @(posedge PCLK);
    $display("[TB] FAIL watchdog: got no completion expected $finish within 150000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic holdCycles(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic countWhile(input logic level, input int limit, output int n);
    n = 0;
    while ((gpio_out === level) && (n < limit)) begin
      @(negedge PCLK);
      n++;
    end
  endtask

  // Reply content straight from the protocol rules: who answers, with what, MSB first.
  function automatic void modelReply(input logic [7:0] cmd, input logic en, input logic [31:0] pad);
    logic [23:0] status;
    status = 24'h05_00_02;
    expBits.delete();
    expValue = 32'h0;
    if (!en) return;
    if ((cmd == 8'h00) || (cmd == 8'hFF)) begin
      for (int i = 23; i >= 0; i--) expBits.push_back(status[i]);
    end else if (cmd == 8'h01) begin
      for (int i = 31; i >= 0; i--) expBits.push_back(pad[i]);
    end
    foreach (expBits[i]) expValue = {expValue[30:0], expBits[i]};
  endfunction

  task automatic sendByte(input logic [7:0] cmd, input int nBits, input int glitchBit, input bit withStop);
    int lowN;
    int highN;
    for (int i = 7; i > 7 - nBits; i--) begin
      lowN  = cmd[i] ? US : 3 * US;
      highN = 4 * US - lowN;
      consoleDrive = 1'b0;
      holdCycles(lowN);
      consoleDrive = 1'b1;
      if (i == glitchBit) begin
        holdCycles(highN / 2);
        consoleDrive = 1'b0;
        holdCycles(US / 8);
        consoleDrive = 1'b1;
        holdCycles(highN - highN / 2 - US / 8);
      end else begin
        holdCycles(highN);
      end
    end
    if (withStop) begin
      consoleDrive = 1'b0;
      holdCycles(US);
      consoleDrive = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic en, input logic [31:0] pad,
                               input logic [31:0] padLater, input int glitchBit);
    int v0;
    int e0;
    int n;
    int lowN;
    int highN;
    logic [31:0] seen;
    v0 = validCount;
    e0 = errorPulseCount;
    seen = 32'h0;
    respond_enable = en;
    button_data = pad;
    modelReply(cmd, en, pad);
    if (glitchBit >= 0) begin
      consoleDrive = 1'b0;
      holdCycles(US / 8);
      consoleDrive = 1'b1;
      holdCycles(2 * US);
    end
    sendByte(cmd, 8, glitchBit, 1'b1);
    countWhile(1'b1, (TURN_US + 6) * US, n);
    checkOutput("cmdValidPulses", 32'(validCount - v0), 32'd1);
    checkOutput("cmdByteAtValid", 32'(validByte), 32'(cmd));
    checkOutput("rxErrorPulses", 32'(errorPulseCount - e0), 32'd0);
    if (expBits.size() == 0) begin
      checkOutput("noReplyLine", 32'(gpio_out), 32'd1);
      checkOutput("noReplyBusy", 32'(busy), 32'd0);
    end else begin
      // Window covers the synchroniser delay between the console release and the rise strobe.
      $display("[TB] cmd %02h reply after %0d cycles", cmd, n);
      checkOutput("turnLatencyInWindow", 32'((n >= TURN_US * US) && (n <= TURN_US * US + 3)), 32'd1);
      button_data = padLater;
      respond_enable = 1'($urandom_range(0, 1));
      foreach (expBits[i]) begin
        countWhile(1'b0, 8 * US, lowN);
        countWhile(1'b1, 8 * US, highN);
        checkOutput("bitLowWidth", 32'(lowN), 32'(expBits[i] ? US : 3 * US));
        checkOutput("bitPeriod", 32'(lowN + highN), 32'(4 * US));
        seen = {seen[30:0], (lowN < 2 * US)};
      end
      checkOutput("replyValue", seen, expValue);
      countWhile(1'b0, 8 * US, lowN);
      checkOutput("stopLowWidth", 32'(lowN), 32'(2 * US));
      n = 0;
      while ((busy === 1'b1) && (n < 8 * US)) begin
        @(negedge PCLK);
        n++;
      end
      checkOutput("recoverInWindow", 32'((n >= 2 * US - 1) && (n <= 2 * US + 1)), 32'd1);
      checkOutput("lineReleasedAfter", 32'(gpio_out), 32'd1);
    end
    checkOutput("cmdByteHeld", 32'(cmd_byte), 32'(cmd));
    holdCycles(US);
  endtask

  initial begin
    int v0;
    int e0;
    int n;
    int kind;
    logic [7:0] rb;

    controller_reset = 1'b1;
    respond_enable = 1'b1;
    button_data = 32'h0;
    consoleDrive = 1'b1;
    holdCycles(4);
    checkOutput("resetGpio", 32'(gpio_out), 32'd1);
    checkOutput("resetCmdValid", 32'(cmd_valid), 32'd0);
    checkOutput("resetCmdByte", 32'(cmd_byte), 32'h00);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetRxError", 32'(rx_error), 32'd0);
    controller_reset = 1'b0;
    holdCycles(2 * US);

    applyStimulus(8'h01, 1'b1, 32'h8000_7F81, 32'h8000_7F81, -1);
    applyStimulus(8'h00, 1'b1, $urandom, $urandom, 5);
    applyStimulus(8'hFF, 1'b1, $urandom, $urandom, -1);
    applyStimulus(8'h42, 1'b1, $urandom, $urandom, -1);
    applyStimulus(8'h01, 1'b0, 32'h1234_5678, 32'h0, -1);

    // Four bits then a long high line must abort reception.
    v0 = validCount;
    e0 = errorPulseCount;
    sendByte(8'h01, 4, -1, 1'b0);
    holdCycles(10 * US);
    checkOutput("timeoutErrorPulses", 32'(errorPulseCount - e0), 32'd1);
    checkOutput("timeoutNoValid", 32'(validCount - v0), 32'd0);
    checkOutput("timeoutIdle", 32'(busy), 32'd0);

    applyStimulus(8'h01, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, -1);

    // Reset in the middle of the second reply byte, while the pad holds the line low.
    respond_enable = 1'b1;
    button_data = 32'h8000_7F81;
    sendByte(8'h01, 8, -1, 1'b1);
    countWhile(1'b1, (TURN_US + 6) * US, n);
    checkOutput("midResetReplyStarted", 32'(gpio_out), 32'd0);
    holdCycles(12 * 4 * US + US);
    checkOutput("midResetLineLow", 32'(gpio_out), 32'd0);
    controller_reset = 1'b1;
    holdCycles(1);
    checkOutput("midResetGpio", 32'(gpio_out), 32'd1);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetCmdByte", 32'(cmd_byte), 32'h00);
    controller_reset = 1'b0;
    holdCycles(2 * US);
    checkOutput("postResetQuiet", 32'(gpio_out), 32'd1);

    for (int k = 0; k < 5; k++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: rb = 8'h00;
        1: rb = 8'hFF;
        2, 3: rb = 8'h01;
        default: begin
          rb = 8'($urandom);
          if ((rb == 8'h00) || (rb == 8'h01) || (rb == 8'hFF)) rb = 8'h5A;
        end
      endcase
      applyStimulus(rb, 1'($urandom_range(0, 3) != 0), $urandom, $urandom, -1);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
